rodada_unidade_controle: RTL and testbench

Moore control unit that sequences the round-based memory-game datapath: address counter, round-limit counter, play register and comparator. Each round *k* requires the player to repeat stored plays 0..k, and a successful round extends the limit by one. The block adds a per-play inactivity timeout. It sits between the top-level game module and the datapath, consuming datapath status and emitting single-purpose control strobes.

---
 rtl/rodada_unidade_controle_pkg.sv | 65 ++++++
 rtl/rodada_unidade_controle_if.sv | 32 +++
 rtl/rodada_unidade_controle_contador_timeout.sv | 39 +++
 rtl/rodada_unidade_controle.sv | 92 +++++++++
 tb/tb_rodada_unidade_controle.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/rodada_unidade_controle_pkg.sv
// Shared definitions for the memory-game round control unit: state codes,
// strobe bundle and the default inactivity timeout.
package rodada_unidade_controle_pkg;

  localparam int unsigned TIMEOUT_CICLOS_PADRAO = 5000;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    ESPERA_JOGADA  = 4'h4,
    REGISTRA       = 4'h5,
    COMPARA        = 4'h6,
    PROXIMA_JOGADA = 4'h7,
    PROXIMA_RODADA = 4'h8,
    FIM_ACERTOS    = 4'hC,
    FIM_TIMEOUT    = 4'hD,
    FIM_ERRO       = 4'hE
  } estado_t;

  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_l;
    logic conta_l;
    logic zera_r;
    logic registra_r;
    logic acertou;
    logic errou;
    logic timeout;
    logic pronto;
  } saidas_t;

  // Moore decode: strobes depend on the state alone.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    case (e)
      INICIAL, PREPARACAO: begin
        s.zera_e = 1'b1;
        s.zera_l = 1'b1;
        s.zera_r = 1'b1;
      end
      INICIA_RODADA:  s.zera_e = 1'b1;
      REGISTRA:       s.registra_r = 1'b1;
      PROXIMA_JOGADA: s.conta_e = 1'b1;
      PROXIMA_RODADA: s.conta_l = 1'b1;
      FIM_ACERTOS: begin
        s.acertou = 1'b1;
        s.pronto  = 1'b1;
      end
      FIM_TIMEOUT: begin
        s.timeout = 1'b1;
        s.pronto  = 1'b1;
      end
      FIM_ERRO: begin
        s.errou  = 1'b1;
        s.pronto = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rodada_unidade_controle_if.sv
// Status/control bundle between the round control unit (slave) and the
// game datapath / top level (master).
interface rodada_unidade_controle_if;
  logic       iniciar;
  logic       jogada;
  logic       igual;
  logic       fimE;
  logic       fimL;
  logic       zeraE;
  logic       contaE;
  logic       zeraL;
  logic       contaL;
  logic       zeraR;
  logic       registraR;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic       pronto;
  logic [3:0] db_estado;

  modport slave (
    input  iniciar, jogada, igual, fimE, fimL,
    output zeraE, contaE, zeraL, contaL, zeraR, registraR,
           acertou, errou, timeout, pronto, db_estado
  );

  modport master (
    output iniciar, jogada, igual, fimE, fimL,
    input  zeraE, contaE, zeraL, contaL, zeraR, registraR,
           acertou, errou, timeout, pronto, db_estado
  );
endinterface

// File: rtl/rodada_unidade_controle_contador_timeout.sv
// Inactivity timer: counts while conta is high, cleared by zera; fim flags
// the last allowed cycle (count == M-1).
module contador_timeout
  import rodada_unidade_controle_pkg::*;
#(
  parameter int unsigned M = TIMEOUT_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int unsigned W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] ULTIMO = W'(M - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (zera) begin
      count_d = '0;
    end else if (conta) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign fim = (count_q == ULTIMO);

endmodule

// File: rtl/rodada_unidade_controle.sv
// Moore control unit for the round-based memory game. Define TIMEOUT_EN to
// add the per-play inactivity timer and the TIMEOUT_CICLOS parameter.
module rodada_unidade_controle
  import rodada_unidade_controle_pkg::*;
`ifdef TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
)
`endif
(
  input  logic                       clock,
  input  logic                       reset,
  rodada_unidade_controle_if.slave   bus
);

  estado_t state_q, state_d;
  saidas_t saidas_q, saidas_d;
  logic    timer_fim;

`ifdef TIMEOUT_EN
  contador_timeout #(
    .M(TIMEOUT_CICLOS)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (state_q != ESPERA_JOGADA),
    .conta (state_q == ESPERA_JOGADA),
    .fim   (timer_fim)
  );
`else
  assign timer_fim = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:        if (bus.iniciar) state_d = PREPARACAO;
      PREPARACAO:     state_d = INICIA_RODADA;
      INICIA_RODADA:  state_d = ESPERA_JOGADA;
      // A play on the expiry cycle still counts.
      ESPERA_JOGADA: begin
        if (bus.jogada)     state_d = REGISTRA;
        else if (timer_fim) state_d = FIM_TIMEOUT;
      end
      REGISTRA:       state_d = COMPARA;
      COMPARA: begin
        if (!bus.igual)     state_d = FIM_ERRO;
        else if (!bus.fimE) state_d = PROXIMA_JOGADA;
        else if (!bus.fimL) state_d = PROXIMA_RODADA;
        else                state_d = FIM_ACERTOS;
      end
      PROXIMA_JOGADA: state_d = ESPERA_JOGADA;
      PROXIMA_RODADA: state_d = INICIA_RODADA;
      FIM_ACERTOS, FIM_TIMEOUT, FIM_ERRO: begin
        if (bus.iniciar) state_d = PREPARACAO;
      end
      default:        state_d = INICIAL;
    endcase
  end

  // Strobes are decoded from the next state and registered alongside it,
  // so they are glitch-free yet still aligned with db_estado.
  always_comb begin
    saidas_d = decodifica(state_d);
`ifndef TIMEOUT_EN
    saidas_d.timeout = 1'b0;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= INICIAL;
      saidas_q <= decodifica(INICIAL);
    end else begin
      state_q  <= state_d;
      saidas_q <= saidas_d;
    end
  end

  assign bus.zeraE     = saidas_q.zera_e;
  assign bus.contaE    = saidas_q.conta_e;
  assign bus.zeraL     = saidas_q.zera_l;
  assign bus.contaL    = saidas_q.conta_l;
  assign bus.zeraR     = saidas_q.zera_r;
  assign bus.registraR = saidas_q.registra_r;
  assign bus.acertou   = saidas_q.acertou;
  assign bus.errou     = saidas_q.errou;
  assign bus.timeout   = saidas_q.timeout;
  assign bus.pronto    = saidas_q.pronto;
  assign bus.db_estado = state_q;

endmodule

// File: tb/tb_rodada_unidade_controle.sv
// Self-checking bench for rodada_unidade_controle: cycle-level scoreboard
// against a reference FSM plus a small bench-side datapath for fimE/fimL.
module tb_rodada_unidade_controle;

  localparam int TC = 10;

  logic clock = 1'b0;
  logic reset;

  rodada_unidade_controle_if bus();

`ifdef TIMEOUT_EN
  rodada_unidade_controle #(.TIMEOUT_CICLOS(TC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
`else
  rodada_unidade_controle dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );
`endif

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [13:0] sb_q[$];
  logic [3:0]  m_state;
  int          m_timer;
  int          e_cnt, l_cnt, wait_cnt;
  int          cnt_contaL, cnt_contaE;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // {state, zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto}
  function automatic logic [13:0] model_vec(input logic [3:0] s);
    logic fim_a, fim_t, fim_e;
    fim_a = (s == 4'hC);
    fim_t = (s == 4'hD);
    fim_e = (s == 4'hE);
    return {s,
            (s == 4'h0) || (s == 4'h1) || (s == 4'h2),
            (s == 4'h7),
            (s == 4'h0) || (s == 4'h1),
            (s == 4'h8),
            (s == 4'h0) || (s == 4'h1),
            (s == 4'h5),
            fim_a, fim_e, fim_t,
            fim_a || fim_t || fim_e};
  endfunction

  function automatic logic [3:0] model_next(input logic [3:0] s, input logic ini, jog, ig, fe, fl, expd);
    case (s)
      4'h0:    return ini ? 4'h1 : 4'h0;
      4'h1:    return 4'h2;
      4'h2:    return 4'h4;
      4'h4:    return jog ? 4'h5 : (expd ? 4'hD : 4'h4);
      4'h5:    return 4'h6;
      4'h6:    return !ig ? 4'hE : (!fe ? 4'h7 : (!fl ? 4'h8 : 4'hC));
      4'h7:    return 4'h4;
      4'h8:    return 4'h2;
      4'hC, 4'hD, 4'hE: return ini ? 4'h1 : s;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus.db_estado, bus.zeraE, bus.contaE, bus.zeraL, bus.contaL, bus.zeraR,
            bus.registraR, bus.acertou, bus.errou, bus.timeout, bus.pronto};
  endfunction

  // One clock: drive at the falling edge, predict, compare 1 time unit after the rising edge.
  task automatic step(input logic rst, ini, jog, ig, fe, fl);
    logic        expd;
    logic [3:0]  ns;
    logic [13:0] got, want;
    reset       = rst;
    bus.iniciar = ini;
    bus.jogada  = jog;
    bus.igual   = ig;
    bus.fimE    = fe;
    bus.fimL    = fl;
`ifdef TIMEOUT_EN
    expd = (m_state == 4'h4) && (m_timer == TC - 1);
`else
    expd = 1'b0;
`endif
    ns = rst ? 4'h0 : model_next(m_state, ini, jog, ig, fe, fl, expd);
    if (rst) begin
      e_cnt = 0;
      l_cnt = 0;
    end else begin
      if (m_state inside {4'h0, 4'h1, 4'h2}) e_cnt = 0;
      else if (m_state == 4'h7) e_cnt++;
      if (m_state inside {4'h0, 4'h1}) l_cnt = 0;
      else if (m_state == 4'h8) l_cnt++;
    end
    m_timer = (!rst && m_state == 4'h4) ? m_timer + 1 : 0;
    m_state = ns;
    sb_q.push_back(model_vec(ns));
    @(posedge clock);
    #1;
    got  = dut_vec();
    want = sb_q.pop_front();
    $display("t=%0t rst=%b ini=%b jog=%b ig=%b fe=%b fl=%b dut=%h model=%h",
             $time, rst, ini, jog, ig, fe, fl, got, want);
    check_eq("cycle", 16'(got), 16'(want));
    if (bus.contaL) cnt_contaL++;
    if (bus.contaE) cnt_contaE++;
    @(negedge clock);
  endtask

  // Automatic player: plays after `delay` idle cycles in espera_jogada,
  // answers wrong at (err_round, err_play); stop_at 15 means any fim_* state.
  task automatic run_game(input int lim, input int err_round, input int err_play,
                          input int delay, input logic [3:0] stop_at);
    int         n;
    logic       done, jog, ig, fe, fl;
    logic [3:0] prev;
    n = 0;
    wait_cnt = 0;
    done = (stop_at == 4'hF) ? (m_state >= 4'hC) : (m_state == stop_at);
    while (!done && n < 300) begin
      jog  = (m_state == 4'h4) && (wait_cnt == delay);
      ig   = !((l_cnt == err_round) && (e_cnt == err_play));
      fe   = (e_cnt == l_cnt);
      fl   = (l_cnt == lim);
      prev = m_state;
      step(1'b0, 1'b0, jog, ig, fe, fl);
      wait_cnt = (prev == 4'h4 && m_state == 4'h4) ? wait_cnt + 1 : 0;
      n++;
      done = (stop_at == 4'hF) ? (m_state >= 4'hC) : (m_state == stop_at);
    end
    check_eq("run_game_reached", 16'(done), 16'd1);
  endtask

  initial begin
    int n;
    reset       = 1'b1;
    bus.iniciar = 1'b0;
    bus.jogada  = 1'b0;
    bus.igual   = 1'b0;
    bus.fimE    = 1'b0;
    bus.fimL    = 1'b0;
    m_state = 4'h0;
    m_timer = 0;
    e_cnt = 0;
    l_cnt = 0;
    @(negedge clock);

    // Reset state and idle hold in inicial.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Full win: limit reaches 2, three rounds.
    cnt_contaL = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_game(2, -1, -1, 0, 4'hF);
    check_eq("win_state", 16'(bus.db_estado), 16'hC);
    check_eq("win_acertou", 16'(bus.acertou), 16'd1);
    check_eq("win_pronto", 16'(bus.pronto), 16'd1);
    check_eq("win_contaL_pulses", 16'(cnt_contaL), 16'd2);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Wrong second play in round 1.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_game(2, 1, 1, 2, 4'hF);
    check_eq("err_state", 16'(bus.db_estado), 16'hE);
    check_eq("err_errou", 16'(bus.errou), 16'd1);
    check_eq("err_pronto", 16'(bus.pronto), 16'd1);
    cnt_contaE = 0;
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("err_no_contaE", 16'(cnt_contaE), 16'd0);

    // Restart from fim_erro.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("restart_prep", 16'(bus.db_estado), 16'h1);
    check_eq("restart_zeraL", 16'(bus.zeraL), 16'd1);
    check_eq("restart_zeraR", 16'(bus.zeraR), 16'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("restart_inicia", 16'(bus.db_estado), 16'h2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Inactivity with no play.
`ifdef TIMEOUT_EN
    n = 0;
    while (bus.db_estado != 4'hD && n < 50) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check_eq("timeout_latency", 16'(n), 16'(TC));
    check_eq("timeout_flag", 16'(bus.timeout), 16'd1);
    check_eq("timeout_pronto", 16'(bus.pronto), 16'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_game(2, -1, -1, TC - 1, 4'h5);
`else
    n = 0;
    repeat (1000) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check_eq("no_timeout_state", 16'(bus.db_estado), 16'h4);
    check_eq("no_timeout_flag", 16'(bus.timeout), 16'd0);
    run_game(2, -1, -1, TC - 1, 4'h5);
`endif
    // Play landing on the expiry cycle must register.
    check_eq("jogada_at_expiry", 16'(bus.db_estado), 16'h5);

    // Asynchronous reset in compara.
    run_game(2, -1, -1, 0, 4'h6);
    check_eq("in_compara", 16'(bus.db_estado), 16'h6);
    reset = 1'b1;
    #1;
    check_eq("async_reset", 16'(dut_vec()), 16'(model_vec(4'h0)));
    m_state = 4'h0;
    m_timer = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
